// File: rtl/control_config_rtc.sv
// Configuration-mode sequencer: turns button pulses into funcion/cursor/format, edits a BCD buffer
// and writes it to the RTC over a req/ack handshake. Optional macro CONFIG_AUTOEXIT_EN adds idle auto-exit.
module control_config_rtc #(
    parameter int ACK_TIMEOUT = 1023
`ifdef CONFIG_AUTOEXIT_EN
    , parameter logic [25:0] IDLE_CYCLES = 26'd50_000_000
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] in_f0,
    input  logic [7:0] in_f1,
    input  logic [7:0] in_f2,
    input  logic       wr_ack,
    output logic [1:0] funcion,
    output logic [1:0] cursor_location,
    output logic [7:0] edit_f0,
    output logic [7:0] edit_f1,
    output logic [7:0] edit_f2,
    output logic       wr_req,
    output logic [1:0] wr_group,
    output logic       wr_error,
    output logic       formato_hora,
    output logic [1:0] fsm_state
);
    // Write handshake: wr_req rises on entry to WRITE and, together with edit_f*/wr_group, holds
    // until the edge after wr_ack is seen high (or the timeout expires); wr_ack is ignored elsewhere.
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_LOAD = 2'd1, S_EDIT = 2'd2, S_WRITE = 2'd3} state_t;

    state_t        state, state_nxt;
    logic [1:0]    fn_nxt, cur_nxt, grp_nxt;
    logic [7:0]    e0_nxt, e1_nxt, e2_nxt;
    logic          req_nxt, err_nxt, fmt_nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic [7:0]    sel_val, sel_min, sel_max, sel_new;
    logic          timeout;
`ifdef CONFIG_AUTOEXIT_EN
    logic [25:0]   idle_cnt, idle_nxt;
    logic          any_pulse;
`endif

    function automatic logic [7:0] field_min(input logic [1:0] grp, input logic [1:0] idx);
        return (grp == 2'b10 && idx != 2'd2) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] field_max(input logic [1:0] grp, input logic [1:0] idx);
        if (grp == 2'b10) return (idx == 2'd0) ? 8'h31 : (idx == 2'd1) ? 8'h12 : 8'h99;
        return (idx == 2'd0) ? 8'h23 : 8'h59;
    endfunction

    // Valid BCD bytes order the same as their numeric values, so raw compares suffice.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < lo || v > hi) return lo;
        return v;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (v == hi) return lo;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (v == lo) return hi;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign fsm_state = state;
    assign timeout   = (cnt == TW'(ACK_TIMEOUT - 1));
    assign sel_val   = (cursor_location == 2'd0) ? edit_f0 : (cursor_location == 2'd1) ? edit_f1 : edit_f2;
    assign sel_min   = field_min(funcion, cursor_location);
    assign sel_max   = field_max(funcion, cursor_location);
    assign sel_new   = btn_up ? bcd_inc(sel_val, sel_min, sel_max) : bcd_dec(sel_val, sel_min, sel_max);
`ifdef CONFIG_AUTOEXIT_EN
    assign any_pulse = btn_mode | btn_left | btn_right | btn_up | btn_down;
`endif

    always_comb begin
        state_nxt = state;
        fn_nxt    = funcion;
        cur_nxt   = cursor_location;
        e0_nxt    = edit_f0;
        e1_nxt    = edit_f1;
        e2_nxt    = edit_f2;
        req_nxt   = wr_req;
        grp_nxt   = wr_group;
        err_nxt   = wr_error;
        fmt_nxt   = formato_hora;
        cnt_nxt   = cnt;
`ifdef CONFIG_AUTOEXIT_EN
        idle_nxt  = '0;
`endif
        case (state)
            S_RUN: begin
                if (btn_mode) begin
                    state_nxt = S_LOAD;
                    fn_nxt    = 2'b01;
                end else if (btn_up || btn_down) begin
                    fmt_nxt = ~formato_hora;
                end
            end
            S_LOAD: begin
                e0_nxt    = bcd_clamp(in_f0, field_min(funcion, 2'd0), field_max(funcion, 2'd0));
                e1_nxt    = bcd_clamp(in_f1, field_min(funcion, 2'd1), field_max(funcion, 2'd1));
                e2_nxt    = bcd_clamp(in_f2, field_min(funcion, 2'd2), field_max(funcion, 2'd2));
                cur_nxt   = 2'd0;
                state_nxt = S_EDIT;
            end
            S_EDIT: begin
`ifdef CONFIG_AUTOEXIT_EN
                idle_nxt = any_pulse ? 26'd0 : idle_cnt + 26'd1;
`endif
                if (btn_mode) begin
                    state_nxt = S_WRITE;
                    req_nxt   = 1'b1;
                    grp_nxt   = funcion;
                    cnt_nxt   = '0;
                end else if (btn_right) begin
                    cur_nxt = (cursor_location == 2'd2) ? 2'd0 : cursor_location + 2'd1;
                end else if (btn_left) begin
                    cur_nxt = (cursor_location == 2'd0) ? 2'd2 : cursor_location - 2'd1;
                end else if (btn_up || btn_down) begin
                    case (cursor_location)
                        2'd0:    e0_nxt = sel_new;
                        2'd1:    e1_nxt = sel_new;
                        default: e2_nxt = sel_new;
                    endcase
`ifdef CONFIG_AUTOEXIT_EN
                end else if (idle_cnt == IDLE_CYCLES - 26'd1) begin
                    state_nxt = S_RUN;
                    fn_nxt    = 2'b00;
                    idle_nxt  = '0;
`endif
                end
            end
            default: begin
                if (wr_ack || timeout) begin
                    req_nxt   = 1'b0;
                    err_nxt   = ~wr_ack;
                    fn_nxt    = funcion + 2'd1;
                    state_nxt = (funcion == 2'b11) ? S_RUN : S_LOAD;
                end else begin
                    cnt_nxt = cnt + TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= S_RUN;
            funcion         <= '0;
            cursor_location <= '0;
            edit_f0         <= 8'h00;
            edit_f1         <= 8'h00;
            edit_f2         <= 8'h00;
            wr_req          <= 1'b0;
            wr_group        <= '0;
            wr_error        <= 1'b0;
            formato_hora    <= 1'b0;
            cnt             <= '0;
`ifdef CONFIG_AUTOEXIT_EN
            idle_cnt        <= '0;
`endif
        end else begin
            state           <= state_nxt;
            funcion         <= fn_nxt;
            cursor_location <= cur_nxt;
            edit_f0         <= e0_nxt;
            edit_f1         <= e1_nxt;
            edit_f2         <= e2_nxt;
            wr_req          <= req_nxt;
            wr_group        <= grp_nxt;
            wr_error        <= err_nxt;
            formato_hora    <= fmt_nxt;
            cnt             <= cnt_nxt;
`ifdef CONFIG_AUTOEXIT_EN
            idle_cnt        <= idle_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_control_config_rtc.sv
// Bench for control_config_rtc: a cycle-by-cycle vector table, then hand sequences for
// write handshake, timeout, sticky error, async reset and (with CONFIG_AUTOEXIT_EN) idle exit.
module tb_control_config_rtc;
    localparam int ACK_TO = 1023;
    localparam logic [1:0] ST_RUN = 2'd0, ST_LOAD = 2'd1, ST_EDIT = 2'd2, ST_WRITE = 2'd3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 0, btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0;
    logic [7:0] in_f0 = 8'h12, in_f1 = 8'h34, in_f2 = 8'h56;
    logic       wr_ack = 0;
    logic [1:0] funcion, cursor_location, wr_group, fsm_state;
    logic [7:0] edit_f0, edit_f1, edit_f2;
    logic       wr_req, wr_error, formato_hora;

    typedef struct packed {
        logic [1:0] fn;
        logic [1:0] cur;
        logic [7:0] e0, e1, e2;
        logic       req;
        logic [1:0] grp;
        logic       err;
        logic       fmt;
        logic [1:0] st;
    } obs_t;

    typedef struct packed {
        logic [4:0] btn;   // {mode, left, right, up, down}
        logic [7:0] f0, f1, f2;
        logic       ack;
        obs_t       exp;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    obs_t act;
    vec_t tbl[$];

    assign act = {funcion, cursor_location, edit_f0, edit_f1, edit_f2,
                  wr_req, wr_group, wr_error, formato_hora, fsm_state};

    control_config_rtc #(
        .ACK_TIMEOUT(ACK_TO)
`ifdef CONFIG_AUTOEXIT_EN
        , .IDLE_CYCLES(26'd100)
`endif
    ) dut (
        .clock(clock), .reset(reset),
        .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down),
        .in_f0(in_f0), .in_f1(in_f1), .in_f2(in_f2), .wr_ack(wr_ack),
        .funcion(funcion), .cursor_location(cursor_location),
        .edit_f0(edit_f0), .edit_f1(edit_f1), .edit_f2(edit_f2),
        .wr_req(wr_req), .wr_group(wr_group), .wr_error(wr_error),
        .formato_hora(formato_hora), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    function automatic obs_t ob(input logic [1:0] fn, input logic [1:0] cur,
                                input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                input logic req, input logic [1:0] grp, input logic err,
                                input logic fmt, input logic [1:0] st);
        return '{fn: fn, cur: cur, e0: e0, e1: e1, e2: e2, req: req, grp: grp, err: err, fmt: fmt, st: st};
    endfunction

    function automatic vec_t mk(input logic [4:0] btn, input logic [7:0] f0, input logic [7:0] f1,
                                input logic [7:0] f2, input logic ack, input obs_t exp);
        return '{btn: btn, f0: f0, f1: f1, f2: f2, ack: ack, exp: exp};
    endfunction

    task automatic check(input string name, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [4:0] btn, input logic ack);
        {btn_mode, btn_left, btn_right, btn_up, btn_down} = btn;
        wr_ack = ack;
        @(posedge clock);
        #1;
        {btn_mode, btn_left, btn_right, btn_up, btn_down} = 5'b0;
        wr_ack = 1'b0;
    endtask

    localparam logic [4:0] B_NONE = 5'b00000, B_M = 5'b10000, B_L = 5'b01000,
                           B_R = 5'b00100, B_U = 5'b00010, B_D = 5'b00001;

    initial begin
        int high;
        // Run/time-edit vectors
        tbl.push_back(mk(B_D,       8'h12, 8'h34, 8'h56, 0, ob(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, ST_RUN)));
        tbl.push_back(mk(B_U,       8'h12, 8'h34, 8'h56, 0, ob(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, ST_RUN)));
        tbl.push_back(mk(B_M | B_U, 8'h12, 8'h34, 8'h56, 0, ob(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, ST_LOAD)));
        tbl.push_back(mk(B_NONE,    8'h12, 8'h34, 8'h56, 0, ob(1, 0, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_L,       8'h12, 8'h34, 8'h56, 0, ob(1, 2, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_L,       8'h12, 8'h34, 8'h56, 0, ob(1, 1, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_L,       8'h12, 8'h34, 8'h56, 0, ob(1, 0, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_R,       8'h12, 8'h34, 8'h56, 0, ob(1, 1, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_R,       8'h12, 8'h34, 8'h56, 0, ob(1, 2, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_R,       8'h12, 8'h34, 8'h56, 0, ob(1, 0, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_U,       8'h12, 8'h34, 8'h56, 0, ob(1, 0, 8'h13, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_D,       8'h12, 8'h34, 8'h56, 0, ob(1, 0, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_R | B_U, 8'h12, 8'h34, 8'h56, 0, ob(1, 1, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_U,       8'h12, 8'h34, 8'h56, 0, ob(1, 1, 8'h12, 8'h35, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_D,       8'h12, 8'h34, 8'h56, 0, ob(1, 1, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_M,       8'h12, 8'h34, 8'h56, 1, ob(1, 1, 8'h12, 8'h34, 8'h56, 1, 1, 0, 0, ST_WRITE)));
        tbl.push_back(mk(B_L,       8'h12, 8'h34, 8'h56, 0, ob(1, 1, 8'h12, 8'h34, 8'h56, 1, 1, 0, 0, ST_WRITE)));
        tbl.push_back(mk(B_NONE,    8'h12, 8'h34, 8'h56, 1, ob(2, 1, 8'h12, 8'h34, 8'h56, 0, 1, 0, 0, ST_LOAD)));
        // Date group: out-of-range fields load minimum; wraps at both ends
        tbl.push_back(mk(B_U,       8'h00, 8'h13, 8'h9A, 0, ob(2, 0, 8'h01, 8'h01, 8'h00, 0, 1, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_D,       8'h00, 8'h13, 8'h9A, 0, ob(2, 0, 8'h31, 8'h01, 8'h00, 0, 1, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_U,       8'h00, 8'h13, 8'h9A, 0, ob(2, 0, 8'h01, 8'h01, 8'h00, 0, 1, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_R,       8'h00, 8'h13, 8'h9A, 0, ob(2, 1, 8'h01, 8'h01, 8'h00, 0, 1, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_D,       8'h00, 8'h13, 8'h9A, 0, ob(2, 1, 8'h01, 8'h12, 8'h00, 0, 1, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_U,       8'h00, 8'h13, 8'h9A, 0, ob(2, 1, 8'h01, 8'h01, 8'h00, 0, 1, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_R,       8'h00, 8'h13, 8'h9A, 0, ob(2, 2, 8'h01, 8'h01, 8'h00, 0, 1, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_D,       8'h00, 8'h13, 8'h9A, 0, ob(2, 2, 8'h01, 8'h01, 8'h99, 0, 1, 0, 0, ST_EDIT)));
        tbl.push_back(mk(B_U,       8'h00, 8'h13, 8'h9A, 0, ob(2, 2, 8'h01, 8'h01, 8'h00, 0, 1, 0, 0, ST_EDIT)));

        repeat (3) @(posedge clock);
        #1;
        check("reset_state", ob(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, ST_RUN));
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            in_f0 = tbl[i].f0;
            in_f1 = tbl[i].f1;
            in_f2 = tbl[i].f2;
            cyc(tbl[i].btn, tbl[i].ack);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Date write acknowledged after 5 waiting cycles
        cyc(B_M, 0);
        check("date_wr_req", ob(2, 2, 8'h01, 8'h01, 8'h00, 1, 2, 0, 0, ST_WRITE));
        for (int i = 0; i < 5; i++) begin
            cyc(B_NONE, 0);
            check("date_wr_hold", ob(2, 2, 8'h01, 8'h01, 8'h00, 1, 2, 0, 0, ST_WRITE));
        end
        in_f0 = 8'h23; in_f1 = 8'h09; in_f2 = 8'h60;
        cyc(B_NONE, 1);
        check("date_ack", ob(3, 2, 8'h01, 8'h01, 8'h00, 0, 2, 0, 0, ST_LOAD));
        cyc(B_NONE, 0);
        check("timer_load", ob(3, 0, 8'h23, 8'h09, 8'h00, 0, 2, 0, 0, ST_EDIT));
        cyc(B_U, 0);
        check("timer_hh_wrap_up", ob(3, 0, 8'h00, 8'h09, 8'h00, 0, 2, 0, 0, ST_EDIT));
        cyc(B_D, 0);
        check("timer_hh_wrap_dn", ob(3, 0, 8'h23, 8'h09, 8'h00, 0, 2, 0, 0, ST_EDIT));
        cyc(B_R, 0);
        cyc(B_U, 0);
        check("timer_mm_carry", ob(3, 1, 8'h23, 8'h10, 8'h00, 0, 2, 0, 0, ST_EDIT));
        cyc(B_D, 0);
        check("timer_mm_borrow", ob(3, 1, 8'h23, 8'h09, 8'h00, 0, 2, 0, 0, ST_EDIT));

        // Timer write never acknowledged
        cyc(B_M, 0);
        check("timer_wr_req", ob(3, 1, 8'h23, 8'h09, 8'h00, 1, 3, 0, 0, ST_WRITE));
        high = 1;
        for (int i = 0; i < 2000; i++) begin
            cyc(B_NONE, 0);
            if (!wr_req) break;
            high++;
        end
        checks++;
        if (high != ACK_TO) begin
            failures++;
            $display("FAIL timeout_len actual=%0d required=%0d", high, ACK_TO);
        end
        check("timeout_state", ob(0, 1, 8'h23, 8'h09, 8'h00, 0, 3, 1, 0, ST_RUN));
        cyc(B_D, 0);
        check("fmt_toggle", ob(0, 1, 8'h23, 8'h09, 8'h00, 0, 3, 1, 1, ST_RUN));

        // Next write with ack clears the sticky error
        in_f0 = 8'h45; in_f1 = 8'h07; in_f2 = 8'h08;
        cyc(B_M, 0);
        cyc(B_NONE, 0);
        check("time_load2", ob(1, 0, 8'h00, 8'h07, 8'h08, 0, 3, 1, 1, ST_EDIT));
        cyc(B_M, 0);
        check("time_wr_req2", ob(1, 0, 8'h00, 8'h07, 8'h08, 1, 1, 1, 1, ST_WRITE));
        cyc(B_NONE, 1);
        check("ack_clears_err", ob(2, 0, 8'h00, 8'h07, 8'h08, 0, 1, 0, 1, ST_LOAD));
        cyc(B_NONE, 0);
        check("date_load2", ob(2, 0, 8'h01, 8'h07, 8'h08, 0, 1, 0, 1, ST_EDIT));

        // Asynchronous reset in the middle of EDIT
        #2 reset = 1'b0;
        #1;
        check("async_reset", ob(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, ST_RUN));
        #2 reset = 1'b1;
        cyc(B_NONE, 0);
        check("after_reset", ob(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, ST_RUN));

        // Idle behaviour in EDIT
        in_f0 = 8'h12; in_f1 = 8'h34; in_f2 = 8'h56;
        cyc(B_M, 0);
        cyc(B_NONE, 0);
        check("idle_entry", ob(1, 0, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT));
`ifdef CONFIG_AUTOEXIT_EN
        begin
            int n;
            logic seen_req;
            n = 0;
            seen_req = 1'b0;
            for (int i = 0; i < 500; i++) begin
                cyc(B_NONE, 0);
                n++;
                if (wr_req) seen_req = 1'b1;
                if (fsm_state == ST_RUN) break;
            end
            checks++;
            if (n != 100 || seen_req) begin
                failures++;
                $display("FAIL autoexit cycles=%0d req_seen=%0d required cycles=100 req_seen=0", n, seen_req);
            end
            check("autoexit_state", ob(0, 0, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_RUN));
        end
`else
        repeat (300) cyc(B_NONE, 0);
        check("edit_held", ob(1, 0, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0, ST_EDIT));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
